lzw_dict_cam: RTL and testbench
===============================

Name: lzw_dict_cam

Overview:
Parametrised LZW dictionary for the RoCC compressor. It stores (prefix code, next char) pairs, not full words, so entry width is independent of string length. A request asks whether string(prefix)+char is already in the dictionary: a hit returns its code, a miss inserts it and returns the new code. Adds over the previous generation:
- valid/ready handshakes
- explicit clear command
- selectable full-dictionary policy (freeze or auto-reset)
- live code-width output for the downstream bit packer

Parameters:
CODE_W, 12, code width in bits; dictionary depth is 2**CODE_W.
CHAR_W, 8, symbol width; literal codes are 0..2**CHAR_W-1.
FIRST_CODE, 258, first dynamic code (256 = CLEAR, 257 = EOF reserved).
FULL_MODE, 0, 0 = freeze when full, 1 = auto-clear after the last insert.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clr_i  in  1  clear-dictionary command (pulse)
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_prefix_i  in  CODE_W  prefix code
req_char_i  in  CHAR_W  appended symbol
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed when valid&ready
resp_hit_o  out  1  string found
resp_code_o  out  CODE_W  matching code (hit), new code (insert), else 0
resp_ins_o  out  1  entry inserted
resp_clr_o  out  1  dictionary auto-cleared after this response
resp_err_o  out  1  prefix >= next_code (illegal)
next_code_o  out  CODE_W+1  next code to be assigned
code_bits_o  out  $clog2(CODE_W+1)  min(CODE_W, floor(log2(next_code))+1)

Behaviour:
- Storage: entries FIRST_CODE..2**CODE_W-1, each {v, prefix, char}. Literals are implicit and never match a (prefix,char) lookup.
- Reset: all v=0, next_code=FIRST_CODE, state IDLE, resp_valid_o=0, req_ready_o=1 and all resp_* outputs 0 in the cycle after rst. code_bits_o=9 for defaults.
- States:
  - IDLE: req_ready_o=1 unless clr_i is high. On accept, latch prefix/char and go to MATCH.
  - MATCH: register per-entry compare results (v & prefix==latched prefix & char==latched char). Go to RESP.
  - RESP: compute hit, priority-encode the lowest matching index, perform the insert/clear side effects once on entry, hold resp_valid_o=1. Return to IDLE on resp_ready_i.
- Latency: accept in cycle T, resp_valid_o high from T+2. Back-to-back throughput is one request per 3 cycles when resp_ready_i is held high.
- Hit: resp_hit=1, resp_code=index, resp_ins=0, no state change.
- Miss with prefix < next_code and next_code < 2**CODE_W:
  - write {1, prefix, char} at next_code, resp_code=next_code, resp_ins=1, then next_code++.
  - Exception: if FULL_MODE=1 and the increment reaches 2**CODE_W, instead clear all v, set next_code=FIRST_CODE, and set resp_clr=1.
- Miss with next_code == 2**CODE_W (only reachable when FULL_MODE=0): resp_hit=0, resp_ins=0, resp_code=0; dictionary unchanged.
- Illegal prefix (>= next_code and >= 2**CHAR_W): resp_err=1, hit=0, ins=0, no write.
- Response outputs are stable while resp_valid_o=1 and resp_ready_i=0; side effects are not repeated.
- clr_i:
  - Honoured only in IDLE. It clears all v and sets next_code=FIRST_CODE in one cycle.
  - If req_valid_i is high in the same cycle, clr_i wins and the request is not accepted that cycle.
  - clr_i in MATCH/RESP is ignored.
- next_code_o and code_bits_o update the cycle after the RESP-entry side effect.
- rst mid-operation aborts any in-flight request; no response is emitted.

Decomposition:
- Package lzw_pkg:
  - entry_t struct {v, prefix, char}
  - CLEAR_CODE=256, EOF_CODE=257
  - state_e enum {IDLE, MATCH, RESP}
  - code-width function
- Sub-module lzw_cam_match: parallel compare of all entries plus lowest-index priority encoder, outputs {hit, index}. Combinational; the parent registers its result in MATCH.

Test Plan:
- After reset, req (prefix=65, char=66) -> T+2 resp_hit=0, ins=1, code=258, next_code=259, code_bits=9.
- Repeat (65,66) -> hit=1, code=258, ins=0, next_code stays 259.
- Fill the dictionary up to next_code=512 -> code_bits goes 9->10 exactly on the transition; lookup (258,67) is accepted as a valid prefix.
- FULL_MODE=0, CODE_W=9: fill to 512, then new string -> hit=0, ins=0, code=0; an existing string still hits.
- FULL_MODE=1, CODE_W=9: the insert at 511 -> code=511, clr=1, next_code=258; the earlier string now misses.
- Hold resp_ready_i=0 for 5 cycles, then assert clr_i together with req_valid_i in IDLE -> outputs stable and a single insert; clr taken, request stalled one cycle, then its lookup misses and gets code 258.

Source files
------------

// File: rtl/lzw_pkg.sv
// lzw_pkg: shared types and helpers for the LZW dictionary CAM.
//   entry_t   - one stored dictionary entry {v, prefix, chr}. Fields use the widest
//               supported widths; narrower instances zero-extend into them.
//   state_e   - request FSM states.
//   code_bits - number of bits the packer needs for the next code, capped at code_w.
package lzw_pkg;

   localparam int unsigned CLEAR_CODE = 256;
   localparam int unsigned EOF_CODE   = 257;

   // Widest code/char supported by entry_t.
   localparam int unsigned MaxCodeW = 16;
   localparam int unsigned MaxCharW = 16;

   typedef enum logic [1:0] {StIdle, StMatch, StResp} state_e;

   typedef struct packed {
      logic                v;
      logic [MaxCodeW-1:0] prefix;
      logic [MaxCharW-1:0] chr;
   } entry_t;

   // min(code_w, floor(log2(nc)) + 1)
   function automatic int unsigned code_bits(input int unsigned nc, input int unsigned code_w);
      int unsigned w;
      w = 1;
      for (int i = 0; i < 32; i++) begin
         if (nc[i]) w = i + 1;
      end
      return (w > code_w) ? code_w : w;
   endfunction

endpackage

// File: rtl/lzw_cam_match.sv
// lzw_cam_match: parallel compare of every dynamic dictionary entry against a
// (prefix, chr) key, followed by a lowest-index priority encoder. Combinational.
//   entries_i - dictionary entries for codes FIRST_CODE .. 2**CODE_W-1
//   prefix_i  - lookup prefix code
//   chr_i     - lookup appended symbol
//   hit_o     - some valid entry matches
//   index_o   - code of the lowest matching entry (0 when no hit)
module lzw_cam_match
   import lzw_pkg::*;
#(
   parameter int unsigned CODE_W     = 12,
   parameter int unsigned CHAR_W     = 8,
   parameter int unsigned FIRST_CODE = 258,
   localparam int unsigned NumEnt    = (1 << CODE_W) - FIRST_CODE
) (
   input  entry_t            entries_i [NumEnt],
   input  logic [CODE_W-1:0] prefix_i,
   input  logic [CHAR_W-1:0] chr_i,
   output logic              hit_o,
   output logic [CODE_W-1:0] index_o
);

   // Scanning downwards lets the lowest matching index win.
   always_comb begin
      hit_o   = 1'b0;
      index_o = '0;
      for (int i = NumEnt - 1; i >= 0; i--) begin
         if (entries_i[i].v &&
             entries_i[i].prefix == MaxCodeW'(prefix_i) &&
             entries_i[i].chr == MaxCharW'(chr_i)) begin
            hit_o   = 1'b1;
            index_o = CODE_W'(i + FIRST_CODE);
         end
      end
   end

endmodule

// File: rtl/lzw_dict_cam.sv
// lzw_dict_cam: LZW dictionary storing (prefix code, next char) pairs.
// A request looks up string(prefix)+char; a hit returns its code, a miss inserts
// it at next_code. Three-state FSM: IDLE accepts, MATCH runs the CAM compare,
// RESP holds the registered response until consumed.
//   clk, rst           - clock, synchronous active-high reset
//   clr_i              - clear-dictionary pulse, honoured only in IDLE (wins over a request)
//   req_*              - request handshake with prefix code and appended symbol
//   resp_*             - response handshake: hit, code, inserted, auto-cleared, illegal prefix
//   next_code_o        - next code to be assigned
//   code_bits_o        - current code width for the downstream bit packer
module lzw_dict_cam
   import lzw_pkg::*;
#(
   parameter int unsigned CODE_W     = 12,
   parameter int unsigned CHAR_W     = 8,
   parameter int unsigned FIRST_CODE = 258,
   parameter int unsigned FULL_MODE  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [CODE_W-1:0]            req_prefix_i,
   input  logic [CHAR_W-1:0]            req_char_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic                         resp_hit_o,
   output logic [CODE_W-1:0]            resp_code_o,
   output logic                         resp_ins_o,
   output logic                         resp_clr_o,
   output logic                         resp_err_o,
   output logic [CODE_W:0]              next_code_o,
   output logic [$clog2(CODE_W+1)-1:0]  code_bits_o
);

   localparam int unsigned Depth  = 1 << CODE_W;
   localparam int unsigned NumEnt = Depth - FIRST_CODE;
   localparam int unsigned NumLit = 1 << CHAR_W;
   localparam int unsigned NcW    = CODE_W + 1;
   localparam int unsigned CbW    = $clog2(CODE_W + 1);
   localparam logic [CODE_W:0] FirstNc = NcW'(FIRST_CODE);
   localparam logic [CODE_W:0] LastNc  = NcW'(Depth - 1);

   state_e              state_q;
   logic                ready_q;
   entry_t              entries_q [NumEnt];
   logic [CODE_W:0]     next_code_q;
   logic [CODE_W-1:0]   prefix_q;
   logic [CHAR_W-1:0]   chr_q;

   logic                resp_valid_q, resp_hit_q, resp_ins_q, resp_clr_q, resp_err_q;
   logic [CODE_W-1:0]   resp_code_q;
   logic                resp_hit_d, resp_ins_d, resp_clr_d, resp_err_d;
   logic [CODE_W-1:0]   resp_code_d;

   logic                match_hit;
   logic [CODE_W-1:0]   match_idx;
   entry_t              new_entry;

   lzw_cam_match #(
      .CODE_W     (CODE_W),
      .CHAR_W     (CHAR_W),
      .FIRST_CODE (FIRST_CODE)
   ) u_match (
      .entries_i (entries_q),
      .prefix_i  (prefix_q),
      .chr_i     (chr_q),
      .hit_o     (match_hit),
      .index_o   (match_idx)
   );

   // Response decision, registered on the MATCH -> RESP edge so side effects
   // happen exactly once per request.
   always_comb begin
      resp_err_d  = ({1'b0, prefix_q} >= next_code_q) && (32'(prefix_q) >= NumLit);
      resp_hit_d  = 1'b0;
      resp_ins_d  = 1'b0;
      resp_clr_d  = 1'b0;
      resp_code_d = '0;
      if (!resp_err_d) begin
         if (match_hit) begin
            resp_hit_d  = 1'b1;
            resp_code_d = match_idx;
         end else if (!next_code_q[CODE_W]) begin
            resp_ins_d  = 1'b1;
            resp_code_d = next_code_q[CODE_W-1:0];
            resp_clr_d  = (FULL_MODE != 0) && (next_code_q == LastNc);
         end
      end
      new_entry = '{v: 1'b1, prefix: MaxCodeW'(prefix_q), chr: MaxCharW'(chr_q)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ready_q      <= 1'b1;
         next_code_q  <= FirstNc;
         prefix_q     <= '0;
         chr_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_ins_q   <= 1'b0;
         resp_clr_q   <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_code_q  <= '0;
         for (int i = 0; i < NumEnt; i++) entries_q[i].v <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (clr_i) begin
                  for (int i = 0; i < NumEnt; i++) entries_q[i].v <= 1'b0;
                  next_code_q <= FirstNc;
               end else if (req_valid_i) begin
                  prefix_q <= req_prefix_i;
                  chr_q    <= req_char_i;
                  ready_q  <= 1'b0;
                  state_q  <= StMatch;
               end
            end
            StMatch: begin
               state_q      <= StResp;
               resp_valid_q <= 1'b1;
               resp_hit_q   <= resp_hit_d;
               resp_ins_q   <= resp_ins_d;
               resp_clr_q   <= resp_clr_d;
               resp_err_q   <= resp_err_d;
               resp_code_q  <= resp_code_d;
               if (resp_clr_d) begin
                  // Last code handed out in auto-reset mode: restart instead of storing.
                  for (int i = 0; i < NumEnt; i++) entries_q[i].v <= 1'b0;
                  next_code_q <= FirstNc;
               end else if (resp_ins_d) begin
                  for (int i = 0; i < NumEnt; i++) begin
                     if (next_code_q == NcW'(i + FIRST_CODE)) entries_q[i] <= new_entry;
                  end
                  next_code_q <= next_code_q + 1'b1;
               end
            end
            StResp: begin
               if (resp_ready_i) begin
                  state_q      <= StIdle;
                  resp_valid_q <= 1'b0;
                  ready_q      <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o  = ready_q & ~clr_i;
   assign resp_valid_o = resp_valid_q;
   assign resp_hit_o   = resp_hit_q;
   assign resp_code_o  = resp_code_q;
   assign resp_ins_o   = resp_ins_q;
   assign resp_clr_o   = resp_clr_q;
   assign resp_err_o   = resp_err_q;
   assign next_code_o  = next_code_q;
   assign code_bits_o  = CbW'(code_bits(32'(next_code_q), CODE_W));

endmodule

// File: tb/tb_lzw_dict_cam.sv
// tb_lzw_dict_cam: three DUT instances (12-bit freeze, 9-bit freeze, 9-bit
// auto-reset) driven with random lookups and checked against an associative-array
// LZW dictionary model.
module tb_lzw_dict_cam;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  req_valid, clr;
   logic [11:0] req_prefix;
   logic [7:0]  req_char;
   logic        resp_ready;

   logic [2:0]  rdy, rv, rhit, rins, rclr, rerr;
   logic [11:0] code0;
   logic [8:0]  code1, code2;
   logic [12:0] nc0;
   logic [9:0]  nc1, nc2;
   logic [3:0]  cb0, cb1, cb2;

   lzw_dict_cam u_dut12 (
      .clk(clk), .rst(rst), .clr_i(clr[0]), .req_valid_i(req_valid[0]), .req_ready_o(rdy[0]),
      .req_prefix_i(req_prefix), .req_char_i(req_char), .resp_valid_o(rv[0]),
      .resp_ready_i(resp_ready), .resp_hit_o(rhit[0]), .resp_code_o(code0),
      .resp_ins_o(rins[0]), .resp_clr_o(rclr[0]), .resp_err_o(rerr[0]),
      .next_code_o(nc0), .code_bits_o(cb0)
   );

   lzw_dict_cam #(.CODE_W(9), .FULL_MODE(0)) u_dut9f (
      .clk(clk), .rst(rst), .clr_i(clr[1]), .req_valid_i(req_valid[1]), .req_ready_o(rdy[1]),
      .req_prefix_i(req_prefix[8:0]), .req_char_i(req_char), .resp_valid_o(rv[1]),
      .resp_ready_i(resp_ready), .resp_hit_o(rhit[1]), .resp_code_o(code1),
      .resp_ins_o(rins[1]), .resp_clr_o(rclr[1]), .resp_err_o(rerr[1]),
      .next_code_o(nc1), .code_bits_o(cb1)
   );

   lzw_dict_cam #(.CODE_W(9), .FULL_MODE(1)) u_dut9w (
      .clk(clk), .rst(rst), .clr_i(clr[2]), .req_valid_i(req_valid[2]), .req_ready_o(rdy[2]),
      .req_prefix_i(req_prefix[8:0]), .req_char_i(req_char), .resp_valid_o(rv[2]),
      .resp_ready_i(resp_ready), .resp_hit_o(rhit[2]), .resp_code_o(code2),
      .resp_ins_o(rins[2]), .resp_clr_o(rclr[2]), .resp_err_o(rerr[2]),
      .next_code_o(nc2), .code_bits_o(cb2)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: one associative dictionary; a per-instance generation
   // number in the key makes a clear a simple bump.
   int unsigned cw [3] = '{12, 9, 9};
   int unsigned fm [3] = '{0, 0, 1};
   int unsigned m_next [3];
   int unsigned m_gen [3];
   int unsigned dict [longint unsigned];
   bit          m_wrapped;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_code(input int k);
      case (k)
         0:       return 32'(code0);
         1:       return 32'(code1);
         default: return 32'(code2);
      endcase
   endfunction

   function automatic logic [31:0] dut_nc(input int k);
      case (k)
         0:       return 32'(nc0);
         1:       return 32'(nc1);
         default: return 32'(nc2);
      endcase
   endfunction

   function automatic logic [31:0] dut_cb(input int k);
      case (k)
         0:       return 32'(cb0);
         1:       return 32'(cb1);
         default: return 32'(cb2);
      endcase
   endfunction

   function automatic longint unsigned mkey(input int k, input int unsigned p, input int unsigned c);
      return (longint'(k) << 56) | (longint'(m_gen[k]) << 32) | (longint'(p) << 8) | longint'(c);
   endfunction

   function automatic int unsigned exp_bits(input int k);
      int unsigned b;
      b = $clog2(m_next[k] + 1);
      return (b > cw[k]) ? cw[k] : b;
   endfunction

   task automatic model_clear(input int k);
      m_next[k] = 258;
      m_gen[k]++;
   endtask

   task automatic check_state(input int k, input string pfx, input logic [31:0] e_hit,
                              input logic [31:0] e_code, input logic [31:0] e_ins,
                              input logic [31:0] e_clr, input logic [31:0] e_err);
      check($sformatf("%s%0d_hit", pfx, k), 32'(rhit[k]), e_hit);
      check($sformatf("%s%0d_code", pfx, k), dut_code(k), e_code);
      check($sformatf("%s%0d_ins", pfx, k), 32'(rins[k]), e_ins);
      check($sformatf("%s%0d_clr", pfx, k), 32'(rclr[k]), e_clr);
      check($sformatf("%s%0d_err", pfx, k), 32'(rerr[k]), e_err);
      check($sformatf("%s%0d_next", pfx, k), dut_nc(k), 32'(m_next[k]));
      check($sformatf("%s%0d_bits", pfx, k), dut_cb(k), 32'(exp_bits(k)));
   endtask

   task automatic do_req(input int k, input int unsigned p, input int unsigned c,
                         input int stall, input bit with_clr);
      int unsigned e_hit, e_code, e_ins, e_clr, e_err;
      int n;
      int lat;
      longint unsigned key;
      @(negedge clk);
      req_prefix   = p[11:0];
      req_char     = c[7:0];
      req_valid[k] = 1'b1;
      resp_ready   = (stall == 0);
      if (with_clr) begin
         clr[k] = 1'b1;
         #1;
         check($sformatf("clr_blocks_ready%0d", k), 32'(rdy[k]), 32'd0);
         @(posedge clk);
         #1 clr[k] = 1'b0;
         model_clear(k);
         @(negedge clk);
      end
      n = 0;
      while (!rdy[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("ready_wait%0d", k), 32'(n < 20), 32'd1);
      @(posedge clk);
      #1 req_valid[k] = 1'b0;

      // Model the request.
      e_hit = 0; e_code = 0; e_ins = 0; e_clr = 0;
      e_err = (p >= m_next[k] && p >= 256) ? 1 : 0;
      key   = mkey(k, p, c);
      if (e_err == 0) begin
         if (dict.exists(key)) begin
            e_hit  = 1;
            e_code = dict[key];
         end else if (m_next[k] < (1 << cw[k])) begin
            e_ins     = 1;
            e_code    = m_next[k];
            dict[key] = m_next[k];
            m_next[k]++;
            if (fm[k] != 0 && m_next[k] == (1 << cw[k])) begin
               e_clr     = 1;
               m_wrapped = 1'b1;
               model_clear(k);
            end
         end
      end

      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rv[k] && lat < 10);
      check($sformatf("latency%0d", k), 32'(lat), 32'd2);
      check_state(k, "resp", e_hit, e_code, e_ins, e_clr, e_err);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check($sformatf("hold_valid%0d", k), 32'(rv[k]), 32'd1);
         check_state(k, "hold", e_hit, e_code, e_ins, e_clr, e_err);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check($sformatf("resp_drop%0d", k), 32'(rv[k]), 32'd0);
      check($sformatf("idle_ready%0d", k), 32'(rdy[k]), 32'd1);
   endtask

   task automatic fill(input int k, input int unsigned stop_next, input bit until_wrap);
      int guard;
      int unsigned p, c;
      guard = 0;
      while (guard < 2000 && (until_wrap ? !m_wrapped : (m_next[k] < stop_next))) begin
         p = $urandom_range(0, m_next[k] - 1);
         c = $urandom_range(0, 255);
         if (guard % 13 == 5 && m_next[k] + 3 < (1 << cw[k]))
            p = m_next[k] + $urandom_range(0, 3);
         do_req(k, p, c, $urandom_range(0, 2), 1'b0);
         guard++;
      end
      check($sformatf("fill_done%0d", k), 32'(guard < 2000), 32'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      clr        = '0;
      req_prefix = '0;
      req_char   = '0;
      resp_ready = 1'b1;
      m_wrapped  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_next[k] = 258;
         m_gen[k]  = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
         check($sformatf("rst_valid%0d", k), 32'(rv[k]), 32'd0);
         check_state(k, "rst", 0, 0, 0, 0, 0);
      end

      // Insert then hit on the wide instance, then fill past the 9->10 bit boundary.
      do_req(0, 65, 66, 0, 1'b0);
      do_req(0, 65, 66, 0, 1'b0);
      fill(0, 512, 1'b0);
      do_req(0, 258, 67, 1, 1'b0);
      do_req(0, 4000, 1, 0, 1'b0);

      // Freeze mode: full dictionary refuses new strings, still finds old ones.
      do_req(1, 65, 66, 0, 1'b0);
      fill(1, 512, 1'b0);
      do_req(1, 511, 5, 0, 1'b0);
      do_req(1, 65, 66, 0, 1'b0);

      // Auto-reset mode: last insert clears the dictionary.
      do_req(2, 65, 66, 0, 1'b0);
      fill(2, 0, 1'b1);
      do_req(2, 65, 66, 0, 1'b0);

      // Stalled response, then clear colliding with a request.
      do_req(0, 100, 7, 5, 1'b0);
      do_req(0, 65, 66, 0, 1'b1);
      do_req(0, 65, 66, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
